// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-serial load/save controller.
// Length codes are byte counts, so they double as loop bounds in the datapath.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    MEM_IDLE  = 2'd0,
    MEM_READ  = 2'd1,
    MEM_WRITE = 2'd2,
    MEM_DONE  = 2'd3
  } mem_state_t;

  localparam logic [2:0] MEM_LEN_B = 3'd1;
  localparam logic [2:0] MEM_LEN_H = 3'd2;
  localparam logic [2:0] MEM_LEN_W = 3'd4;

  function automatic logic len_ok(input logic [2:0] len);
    return (len == MEM_LEN_B) || (len == MEM_LEN_H) || (len == MEM_LEN_W);
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Request bus from EX_MEM plus the 8-bit RAM port, bundled for the controller.
// The master side is the surrounding pipeline together with the RAM.
interface mem_ctrl_if #(parameter int ADDR_W = 32) ();
  logic              load;
  logic              save;
  logic [31:0]       sl_reg_address;
  logic [31:0]       sl_data;
  logic [2:0]        sl_data_length;
  logic              sl_data_signed;
  logic              stall;
  logic              done;
  logic [31:0]       load_data;
  logic [ADDR_W-1:0] mem_a;
  logic [7:0]        mem_dout;
  logic              mem_wr;
  logic [7:0]        mem_din;

  modport master (
    output load, save, sl_reg_address, sl_data, sl_data_length, sl_data_signed, mem_din,
    input  stall, done, load_data, mem_a, mem_dout, mem_wr
  );

  modport slave (
    input  load, save, sl_reg_address, sl_data, sl_data_length, sl_data_signed, mem_din,
    output stall, done, load_data, mem_a, mem_dout, mem_wr
  );
endinterface

// File: rtl/mem_ctrl_ext.sv
// Sign/zero extension of an assembled little-endian load value.
// Kept combinational and standalone so other load paths can share it.
module mem_ext
  import mem_ctrl_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [2:0]  len,
  input  logic        sgn,
  output logic [31:0] ext
);

  always_comb begin
    ext = raw;
    case (len)
      MEM_LEN_B: ext = {{24{sgn & raw[7]}}, raw[7:0]};
      MEM_LEN_H: ext = {{16{sgn & raw[15]}}, raw[15:0]};
      default:   ext = raw;
    endcase
  end

endmodule

// File: rtl/mem_ctrl.sv
// MEM-stage responder: serialises loads/saves onto an 8-bit RAM, one byte
// per cycle little-endian, stalling the pipeline until the access completes.
//
// state | meaning
// IDLE  | waiting; a valid request is latched and its first byte driven
// READ  | presenting addresses and capturing bytes one cycle later
// WRITE | writing one byte per cycle
// DONE  | one-cycle completion pulse; the stale request copy is ignored
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic     clk,
  input  logic     rst,
  mem_ctrl_if.slave bus
);

  mem_state_t        state_q, state_d;
  logic [2:0]        k_q;
  logic [2:0]        len_q;
  logic              sgn_q;
  logic [31:0]       data_q;
  logic [31:0]       rd_buf;
  logic [31:0]       rd_merge;
  logic [31:0]       ext_val;
  logic [1:0]        rd_idx;
  logic [ADDR_W-1:0] mem_a_q;
  logic [7:0]        mem_dout_q;
  logic              mem_wr_q;
  logic              done_q;
  logic [31:0]       load_data_q;
  logic              req_valid;
  logic              last_wr;
  logic              last_rd;

  assign req_valid = (bus.load | bus.save) && len_ok(bus.sl_data_length);
  assign last_wr   = (k_q == 3'(len_q - 3'd1));
  assign last_rd   = (k_q == len_q);

  // In READ the counter runs one ahead of the byte being captured.
  assign rd_idx = k_q[1:0] - 2'd1;

  always_comb begin
    rd_merge = rd_buf;
    rd_merge[{rd_idx, 3'b000} +: 8] = bus.mem_din;
  end

  mem_ext u_ext (
    .raw (rd_merge),
    .len (len_q),
    .sgn (sgn_q),
    .ext (ext_val)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      MEM_IDLE:  if (req_valid) state_d = bus.save ? MEM_WRITE : MEM_READ;
      MEM_WRITE: if (last_wr) state_d = MEM_DONE;
      MEM_READ:  if (last_rd) state_d = MEM_DONE;
      MEM_DONE:  state_d = MEM_IDLE;
      default:   state_d = MEM_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= MEM_IDLE;
      k_q         <= '0;
      len_q       <= '0;
      sgn_q       <= 1'b0;
      data_q      <= '0;
      rd_buf      <= '0;
      mem_a_q     <= '0;
      mem_dout_q  <= '0;
      mem_wr_q    <= 1'b0;
      done_q      <= 1'b0;
      load_data_q <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      case (state_q)
        MEM_IDLE: begin
          if (req_valid) begin
            mem_a_q    <= bus.sl_reg_address[ADDR_W-1:0];
            mem_wr_q   <= bus.save;
            mem_dout_q <= bus.sl_data[7:0];
            data_q     <= bus.sl_data;
            len_q      <= bus.sl_data_length;
            sgn_q      <= bus.sl_data_signed;
            k_q        <= '0;
            rd_buf     <= '0;
          end
        end
        MEM_WRITE: begin
          if (last_wr) begin
            mem_wr_q <= 1'b0;
            done_q   <= 1'b1;
          end else begin
            k_q        <= k_q + 3'd1;
            mem_a_q    <= mem_a_q + ADDR_W'(1);
            mem_dout_q <= data_q[{k_q[1:0] + 2'd1, 3'b000} +: 8];
          end
        end
        MEM_READ: begin
          if (k_q != 3'd0) rd_buf <= rd_merge;
          if (last_rd) begin
            load_data_q <= ext_val;
            done_q      <= 1'b1;
          end else begin
            k_q <= k_q + 3'd1;
            if (k_q < 3'(len_q - 3'd1)) mem_a_q <= mem_a_q + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.stall     = rst && (((state_q == MEM_IDLE) && req_valid) ||
                                 (state_q == MEM_READ) || (state_q == MEM_WRITE));
  assign bus.done      = done_q;
  assign bus.load_data = load_data_q;
  assign bus.mem_a     = mem_a_q;
  assign bus.mem_dout  = mem_dout_q;
  assign bus.mem_wr    = mem_wr_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: byte RAM environment, memory-level reference model with
// a per-cycle compare, and directed requests with literal expectations.
module tb_mem_ctrl;
  localparam int ADDR_W = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_ctrl_if #(.ADDR_W(ADDR_W)) bus ();
  mem_ctrl #(.ADDR_W(ADDR_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_errors = 0;
  int wr_count = 0;

  bit [7:0] ram  [bit [31:0]];
  bit [7:0] gold [bit [31:0]];

  function automatic bit [7:0] ram_rd(input bit [31:0] a);
    return ram.exists(a) ? ram[a] : 8'h00;
  endfunction

  function automatic bit [7:0] gold_rd(input bit [31:0] a);
    return gold.exists(a) ? gold[a] : 8'h00;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit req_valid();
    return (bus.load | bus.save) &&
           (bus.sl_data_length == 3'd1 || bus.sl_data_length == 3'd2 || bus.sl_data_length == 3'd4);
  endfunction

  // RAM environment: synchronous write, registered read.
  always @(posedge clk) begin
    bit [7:0] t;
    t = ram_rd(bus.mem_a);
    if (bus.mem_wr) begin
      ram[bus.mem_a] = bus.mem_dout;
      wr_count++;
    end
    bus.mem_din <= t;
  end

  // Reference model: a request occupies L cycles after acceptance, the last being done.
  bit          m_busy = 1'b0;
  bit          m_save = 1'b0;
  int          m_c = 0, m_L = 0, m_n = 0;
  logic [31:0] m_addr = '0, m_data = '0, m_exp = '0, m_last = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy = 1'b0;
      m_c    = 0;
      m_last = '0;
    end else if (m_busy) begin
      if (m_c == m_L) begin
        m_busy = 1'b0;
        if (!m_save) m_last = m_exp;
      end else begin
        m_c++;
      end
    end else if (req_valid()) begin
      m_busy = 1'b1;
      m_c    = 1;
      m_save = bus.save;
      m_addr = bus.sl_reg_address;
      m_data = bus.sl_data;
      m_n    = int'(bus.sl_data_length);
      m_L    = m_save ? m_n + 1 : m_n + 2;
      if (m_save) begin
        for (int i = 0; i < m_n; i++) gold[m_addr + 32'(i)] = m_data[8*i +: 8];
      end else begin
        longint unsigned mask;
        m_exp = '0;
        for (int i = 0; i < m_n; i++) m_exp = m_exp | (32'(gold_rd(m_addr + 32'(i))) << (8*i));
        mask = (64'd1 << (8*m_n)) - 64'd1;
        if (bus.sl_data_signed && m_exp[8*m_n-1]) m_exp = m_exp | ~mask[31:0];
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("rst_stall", 32'(bus.stall), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_mem_wr", 32'(bus.mem_wr), 32'd0);
      check("rst_load_data", bus.load_data, 32'd0);
    end else if (m_busy) begin
      check("stall", 32'(bus.stall), 32'(m_c < m_L));
      check("done", 32'(bus.done), 32'(m_c == m_L));
      check("mem_wr", 32'(bus.mem_wr), 32'(m_save && m_c <= m_n));
      if (m_c <= m_n) begin
        check("mem_a", bus.mem_a, m_addr + 32'(m_c - 1));
        if (m_save) check("mem_dout", 32'(bus.mem_dout), 32'(m_data[8*(m_c-1) +: 8]));
      end
      check("load_data", bus.load_data, (!m_save && m_c == m_L) ? m_exp : m_last);
    end else begin
      check("idle_stall", 32'(bus.stall), 32'(req_valid()));
      check("idle_done", 32'(bus.done), 32'd0);
      check("idle_mem_wr", 32'(bus.mem_wr), 32'd0);
      check("idle_load_data", bus.load_data, m_last);
    end
  end

  task automatic set_in(input logic ld, input logic sv, input logic [31:0] a, input logic [31:0] d,
                        input logic [2:0] len, input logic sg);
    bus.load = ld; bus.save = sv; bus.sl_reg_address = a; bus.sl_data = d;
    bus.sl_data_length = len; bus.sl_data_signed = sg;
  endtask

  // Called just after a rising edge; returns cycles from acceptance to done.
  task automatic req(input logic ld, input logic sv, input logic [31:0] a, input logic [31:0] d,
                     input logic [2:0] len, input logic sg, output int lat, output logic [31:0] ldv);
    set_in(ld, sv, a, d, len, sg);
    lat = -1;
    ldv = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.done) begin
        lat = i;
        ldv = bus.load_data;
        break;
      end
    end
    if (lat < 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL req_timeout: no done for addr %h within 20 cycles", a);
    end
    @(posedge clk); #1;
    set_in(1'b0, 1'b0, '0, '0, 3'd0, 1'b0);
  endtask

  int          lat;
  logic [31:0] ldv;
  int          w0;

  initial begin
    set_in(1'b0, 1'b0, '0, '0, 3'd0, 1'b0);
    ram[32'h20] = 8'h80;  gold[32'h20] = 8'h80;
    ram[32'h30] = 8'h01;  gold[32'h30] = 8'h01;
    ram[32'h31] = 8'hF0;  gold[32'h31] = 8'hF0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_mem_a", bus.mem_a, 32'd0);
    check("reset_mem_dout", 32'(bus.mem_dout), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Word save then load
    req(1'b0, 1'b1, 32'h100, 32'h8899AABB, 3'd4, 1'b0, lat, ldv);
    check("sw_latency", 32'(lat), 32'd5);
    check("sw_b0", 32'(ram_rd(32'h100)), 32'hBB);
    check("sw_b1", 32'(ram_rd(32'h101)), 32'hAA);
    check("sw_b2", 32'(ram_rd(32'h102)), 32'h99);
    check("sw_b3", 32'(ram_rd(32'h103)), 32'h88);
    req(1'b1, 1'b0, 32'h100, 32'h0, 3'd4, 1'b1, lat, ldv);
    check("lw_latency", 32'(lat), 32'd6);
    check("lw_data", ldv, 32'h8899AABB);

    // Byte extension
    req(1'b1, 1'b0, 32'h20, 32'h0, 3'd1, 1'b1, lat, ldv);
    check("lb_latency", 32'(lat), 32'd3);
    check("lb_data", ldv, 32'hFFFFFF80);
    req(1'b1, 1'b0, 32'h20, 32'h0, 3'd1, 1'b0, lat, ldv);
    check("lbu_latency", 32'(lat), 32'd3);
    check("lbu_data", ldv, 32'h00000080);

    // Halfword extension
    req(1'b1, 1'b0, 32'h30, 32'h0, 3'd2, 1'b1, lat, ldv);
    check("lh_latency", 32'(lat), 32'd4);
    check("lh_data", ldv, 32'hFFFFF001);
    req(1'b1, 1'b0, 32'h30, 32'h0, 3'd2, 1'b0, lat, ldv);
    check("lhu_data", ldv, 32'h0000F001);

    // Back-to-back save then load of the same byte
    w0 = wr_count;
    req(1'b0, 1'b1, 32'h50, 32'h0000005A, 3'd1, 1'b0, lat, ldv);
    check("sb_latency", 32'(lat), 32'd2);
    req(1'b1, 1'b0, 32'h50, 32'h0, 3'd1, 1'b0, lat, ldv);
    check("b2b_write_count", 32'(wr_count - w0), 32'd1);
    check("b2b_load", ldv, 32'h0000005A);

    // Address wrap across the top of memory
    req(1'b0, 1'b1, 32'hFFFFFFFE, 32'h44332211, 3'd4, 1'b0, lat, ldv);
    check("wrap_top", 32'(ram_rd(32'hFFFFFFFF)), 32'h22);
    check("wrap_zero", 32'(ram_rd(32'h0)), 32'h33);
    req(1'b1, 1'b0, 32'hFFFFFFFE, 32'h0, 3'd4, 1'b0, lat, ldv);
    check("wrap_lw", ldv, 32'h44332211);

    // Illegal lengths are ignored
    w0 = wr_count;
    set_in(1'b1, 1'b0, 32'h20, 32'h0, 3'd0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    set_in(1'b0, 1'b1, 32'h60, 32'hDEADBEEF, 3'd3, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("illegal_no_write", 32'(wr_count - w0), 32'd0);
    check("illegal_no_done", 32'(bus.done), 32'd0);
    set_in(1'b0, 1'b0, '0, '0, 3'd0, 1'b0);
    @(posedge clk); #1;

    // load and save together act as a save
    req(1'b1, 1'b1, 32'h40, 32'h000000C3, 3'd1, 1'b0, lat, ldv);
    check("both_latency", 32'(lat), 32'd2);
    check("both_written", 32'(ram_rd(32'h40)), 32'hC3);
    req(1'b1, 1'b0, 32'h40, 32'h0, 3'd1, 1'b1, lat, ldv);
    check("both_readback", ldv, 32'hFFFFFFC3);

    // Reset during the second byte of a word save
    set_in(1'b0, 1'b1, 32'h200, 32'h0D0C0B0A, 3'd4, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("rst_async_mem_wr", 32'(bus.mem_wr), 32'd0);
    set_in(1'b0, 1'b0, '0, '0, 3'd0, 1'b0);
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    @(posedge clk); #1;
    check("post_rst_stall", 32'(bus.stall), 32'd0);
    check("post_rst_done", 32'(bus.done), 32'd0);
    check("rst_byte0", 32'(ram_rd(32'h200)), 32'h0A);
    check("rst_byte1", 32'(ram_rd(32'h201)), 32'h00);
    check("rst_byte2", 32'(ram_rd(32'h202)), 32'h00);

    req(1'b1, 1'b0, 32'h20, 32'h0, 3'd1, 1'b0, lat, ldv);
    check("recover_lbu", ldv, 32'h00000080);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
